// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Supports per-requester ownership locks. Results are registered and returned one cycle after the transfer.
`ifndef ALU_ADD_OP
`define ALU_ADD_OP 4'b0000
`endif

module alu_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int LOCK_MAX = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_lock,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [4*NUM_REQ-1:0]  req_op,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [3:0]            alu_op,
   input  logic [31:0]           alu_result,
   input  logic                  alu_zero,
   output logic [NUM_REQ-1:0]    resp_valid,
   output logic [31:0]           resp_result,
   output logic                  resp_zero
);

   localparam int                 IDX_W      = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
   localparam logic [7:0]         LOCK_LIMIT = 8'(LOCK_MAX);
   localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic               locked_q, locked_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [7:0]         lock_cnt_q, lock_cnt_d;
   logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
   logic [31:0]        resp_result_q, resp_result_d;
   logic               resp_zero_q, resp_zero_d;

   logic [NUM_REQ-1:0]            above_last;
   logic [NUM_REQ-1:0]            owner_oh;
   logic [NUM_REQ-1:0]            rr_hi;
   logic [NUM_REQ-1:0]            rr_pick;
   logic [NUM_REQ:0][31:0]        a_acc;
   logic [NUM_REQ:0][31:0]        b_acc;
   logic [NUM_REQ:0][3:0]         op_acc;
   logic [NUM_REQ:0][IDX_W-1:0]   idx_acc;
   logic                          xfer;
   logic                          xfer_lock;
   logic [IDX_W-1:0]              xfer_idx;
   logic [7:0]                    lock_cnt_inc;

   // Per-requester masks plus OR-chains that mux the one-hot winner's fields.
   assign a_acc[0]   = '0;
   assign b_acc[0]   = '0;
   assign op_acc[0]  = '0;
   assign idx_acc[0] = '0;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign above_last[gi]  = (IDX_W'(gi) > last_grant_q);
      assign owner_oh[gi]    = (owner_q == IDX_W'(gi));
      assign a_acc[gi+1]     = a_acc[gi] | ({32{req_ready[gi]}} & req_a[32*gi +: 32]);
      assign b_acc[gi+1]     = b_acc[gi] | ({32{req_ready[gi]}} & req_b[32*gi +: 32]);
      assign op_acc[gi+1]    = op_acc[gi] | ({4{req_ready[gi]}} & req_op[4*gi +: 4]);
      assign idx_acc[gi+1]   = idx_acc[gi] | (req_ready[gi] ? IDX_W'(gi) : '0);
   end

   assign xfer      = |req_ready;
   assign xfer_lock = |(req_ready & req_lock);
   assign xfer_idx  = idx_acc[NUM_REQ];

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q  <= LAST_IDX;
         locked_q      <= 1'b0;
         owner_q       <= '0;
         lock_cnt_q    <= '0;
         resp_valid_q  <= '0;
         resp_result_q <= '0;
         resp_zero_q   <= 1'b0;
      end else begin
         last_grant_q  <= last_grant_d;
         locked_q      <= locked_d;
         owner_q       <= owner_d;
         lock_cnt_q    <= lock_cnt_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_zero_q   <= resp_zero_d;
      end
   end

   always_comb begin
      last_grant_d  = last_grant_q;
      locked_d      = locked_q;
      owner_d       = owner_q;
      lock_cnt_d    = lock_cnt_q;
      resp_valid_d  = '0;
      resp_result_d = resp_result_q;
      resp_zero_d   = resp_zero_q;
      lock_cnt_inc  = lock_cnt_q + 8'd1;

      if (xfer) begin
         resp_valid_d  = req_ready;
         resp_result_d = alu_result;
         resp_zero_d   = alu_zero;
         last_grant_d  = xfer_idx;
      end

      // While locked only the owner can transfer, so no xfer means an idle owner.
      if (!locked_q) begin
         if (xfer && xfer_lock && (LOCK_MAX > 1)) begin
            locked_d   = 1'b1;
            owner_d    = xfer_idx;
            lock_cnt_d = 8'd1;
         end
      end else if (xfer && xfer_lock) begin
         lock_cnt_d = lock_cnt_inc;
         if (lock_cnt_inc >= LOCK_LIMIT) begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
         end
      end else begin
         locked_d   = 1'b0;
         lock_cnt_d = '0;
      end
   end

   always_comb begin
      rr_hi   = req_valid & above_last;
      rr_pick = (|rr_hi) ? (rr_hi & (~rr_hi + ONE)) : (req_valid & (~req_valid + ONE));
      if (reset) begin
         req_ready = '0;
      end else if (locked_q) begin
         req_ready = req_valid & owner_oh;
      end else begin
         req_ready = rr_pick;
      end
      alu_a  = a_acc[NUM_REQ];
      alu_b  = b_acc[NUM_REQ];
      alu_op = xfer ? op_acc[NUM_REQ] : `ALU_ADD_OP;
   end

   assign resp_valid  = resp_valid_q;
   assign resp_result = resp_result_q;
   assign resp_zero   = resp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small ALU model and a cycle-level reference model of the arbitration rules.
// Directed scenarios carry hand-computed grant and result expectations.
`ifndef ALU_ADD_OP
`define ALU_ADD_OP 4'b0000
`endif

module tb_alu_arbiter;
   localparam int NREQ = 2;
   localparam int LMAX = 8;
   localparam logic [3:0] OP_ADD = `ALU_ADD_OP;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_lock, req_ready, resp_valid;
   logic [31:0] a0, a1, b0, b1;
   logic [3:0]  op0, op1;
   logic [63:0] req_a, req_b;
   logic [7:0]  req_op;
   logic [31:0] alu_a, alu_b, alu_result, resp_result;
   logic [3:0]  alu_op;
   logic        alu_zero, resp_zero;

   int checks = 0;
   int errors = 0;

   assign req_a  = {a1, a0};
   assign req_b  = {b1, b0};
   assign req_op = {op1, op0};

   always #5 clk = ~clk;

   alu_arbiter #(.NUM_REQ(NREQ), .LOCK_MAX(LMAX)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_lock(req_lock),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .req_ready(req_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_zero(resp_zero)
   );

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // The shared ALU lives outside the arbiter.
   always_comb begin
      alu_result = alu_fn(alu_a, alu_b, alu_op);
      alu_zero   = (alu_result == 32'd0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: state after each edge, compared against the DUT every cycle.
   int          m_last, m_owner, m_cnt;
   bit          m_locked, m_init;
   logic [1:0]  m_rv;
   logic [31:0] m_res;
   logic        m_zero;

   initial m_init = 1'b0;

   always @(negedge clk) begin
      int          win;
      int          c;
      logic [1:0]  e_ready;
      logic [31:0] fa, fb;
      logic [3:0]  fop;
      bit          lk;

      win = -1;
      if (!reset) begin
         if (m_locked) begin
            if (((req_valid >> m_owner) & 2'b01) != 2'b00) win = m_owner;
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               c = (m_last + k) % NREQ;
               if (win < 0 && ((req_valid >> c) & 2'b01) != 2'b00) win = c;
            end
         end
      end
      e_ready = '0;
      fa = 32'd0;
      fb = 32'd0;
      fop = `ALU_ADD_OP;
      if (win >= 0) begin
         e_ready = 2'(1 << win);
         fa  = 32'(req_a >> (32 * win));
         fb  = 32'(req_b >> (32 * win));
         fop = 4'(req_op >> (4 * win));
      end

      if (m_init) begin
         chk("model_ready", req_ready, e_ready);
         chk("model_alu_a", alu_a, fa);
         chk("model_alu_b", alu_b, fb);
         chk("model_alu_op", alu_op, fop);
         chk("model_resp_valid", resp_valid, m_rv);
         chk("model_resp_result", resp_result, m_res);
         chk("model_resp_zero", resp_zero, m_zero);
      end

      if (reset) begin
         m_last = NREQ - 1; m_locked = 0; m_owner = 0; m_cnt = 0;
         m_rv = '0; m_res = '0; m_zero = 1'b0; m_init = 1'b1;
      end else if (win >= 0) begin
         m_rv   = e_ready;
         m_res  = alu_fn(fa, fb, fop);
         m_zero = (m_res == 32'd0);
         m_last = win;
         lk = (((req_lock >> win) & 2'b01) != 2'b00);
         if (!m_locked) begin
            if (lk && LMAX > 1) begin
               m_locked = 1; m_owner = win; m_cnt = 1;
            end
         end else if (lk) begin
            m_cnt++;
            if (m_cnt >= LMAX) m_locked = 0;
         end else begin
            m_locked = 0;
         end
      end else begin
         m_rv = '0;
         m_locked = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0]  t2_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
   logic [31:0] t2_res [4] = '{32'd2, 32'd0, 32'd2, 32'd0};
   logic [1:0]  t3_rdy [5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

   initial begin
      reset = 1'b1; req_valid = '0; req_lock = '0;
      a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = OP_ADD; op1 = OP_ADD;
      tick(); tick();
      @(negedge clk);
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_resp_valid", resp_valid, 2'b00);
      chk("rst_resp_result", resp_result, 32'd0);
      chk("rst_resp_zero", resp_zero, 1'b0);
      tick();

      // Single ADD request
      reset = 1'b0; req_valid = 2'b01; a0 = 32'd5; b0 = 32'd7; op0 = OP_ADD;
      @(negedge clk); chk("t1_ready", req_ready, 2'b01);
      tick(); req_valid = 2'b00;
      @(negedge clk);
      chk("t1_resp_valid", resp_valid, 2'b01);
      chk("t1_resp_result", resp_result, 32'd12);
      chk("t1_resp_zero", resp_zero, 1'b0);
      chk("t1_idle_op", alu_op, OP_ADD);
      tick();

      // Both valid: alternation (last winner was req0)
      req_valid = 2'b11; a0 = 32'd9; b0 = 32'd9; op0 = OP_SUB; a1 = 32'd3; b1 = 32'd1; op1 = OP_XOR;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_ready", req_ready, t2_rdy[k]);
         if (k > 0) chk("t2_result", resp_result, t2_res[k-1]);
         tick();
      end
      req_valid = 2'b00;
      @(negedge clk);
      chk("t2_last_result", resp_result, t2_res[3]);
      chk("t2_last_zero", resp_zero, 1'b1);
      tick();

      // req1 lock sequence while req0 waits
      req_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         req_lock = (k < 3) ? 2'b10 : 2'b00;
         @(negedge clk);
         chk("t3_ready", req_ready, t3_rdy[k]);
         tick();
      end
      req_valid = 2'b00; req_lock = 2'b00;
      tick();

      // Forced release after LOCK_MAX transfers
      req_valid = 2'b10;
      @(negedge clk); chk("t4_pre_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b11; req_lock = 2'b01;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("t4_ready", req_ready, (k == 8) ? 2'b10 : 2'b01);
         tick();
      end
      req_valid = 2'b00; req_lock = 2'b00;
      @(negedge clk); chk("t4_idle_ready", req_ready, 2'b00);
      tick();

      // Lock released by idle owner
      req_valid = 2'b01; req_lock = 2'b01;
      @(negedge clk); chk("t5_lock_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b10; req_lock = 2'b00;
      @(negedge clk); chk("t5_idle_ready", req_ready, 2'b00);
      tick();
      @(negedge clk); chk("t5_next_ready", req_ready, 2'b10);
      tick();
      req_valid = 2'b00;
      tick();

      // Reset mid-stream with a fresh lock held by req0
      req_valid = 2'b01; req_lock = 2'b01; a0 = 32'd100; b0 = 32'd1; op0 = OP_ADD;
      @(negedge clk); chk("t6_ready", req_ready, 2'b01);
      tick();
      reset = 1'b1; req_valid = 2'b11;
      @(negedge clk);
      chk("t6_rst_ready", req_ready, 2'b00);
      chk("t6_inflight_valid", resp_valid, 2'b01);
      chk("t6_inflight_result", resp_result, 32'd101);
      tick();
      reset = 1'b0; req_lock = 2'b00;
      @(negedge clk);
      chk("t6_post_resp_valid", resp_valid, 2'b00);
      chk("t6_post_resp_result", resp_result, 32'd0);
      chk("t6_post_ready", req_ready, 2'b01);
      tick();
      @(negedge clk);
      chk("t6_second_ready", req_ready, 2'b10);
      chk("t6_second_result", resp_result, 32'd101);
      tick();
      req_valid = 2'b00;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
